// File: rtl/mcpu_pkg.sv
// Shared register-file constants for the CPU core.
// Also holds the round-robin pointer type used by the writeback arbiter.
package mcpu_pkg;

   localparam int unsigned AW       = 5;
   localparam int unsigned DW       = 32;
   localparam int unsigned NREG     = 32;
   localparam int unsigned REG_ZERO = 0;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, issue, query and register-file write signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface rf_wb_arbiter_if #(
   parameter int unsigned AW = mcpu_pkg::AW,
   parameter int unsigned DW = mcpu_pkg::DW
);

   logic          wb0_valid;
   logic [AW-1:0] wb0_addr;
   logic [DW-1:0] wb0_data;
   logic          wb0_ready;
   logic          wb1_valid;
   logic [AW-1:0] wb1_addr;
   logic [DW-1:0] wb1_data;
   logic          wb1_ready;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic          iss_ready;
   logic [AW-1:0] q_a1;
   logic [AW-1:0] q_a2;
   logic          q_busy1;
   logic          q_busy2;
   logic          rf_wr;
   logic [AW-1:0] rf_a3;
   logic [DW-1:0] rf_wd;

   modport slave (
      input  wb0_valid, wb0_addr, wb0_data,
      output wb0_ready,
      input  wb1_valid, wb1_addr, wb1_data,
      output wb1_ready,
      input  iss_valid, iss_rd,
      output iss_ready,
      input  q_a1, q_a2,
      output q_busy1, q_busy2,
      output rf_wr, rf_a3, rf_wd
   );

   modport master (
      output wb0_valid, wb0_addr, wb0_data,
      input  wb0_ready,
      output wb1_valid, wb1_addr, wb1_data,
      input  wb1_ready,
      output iss_valid, iss_rd,
      input  iss_ready,
      output q_a1, q_a2,
      input  q_busy1, q_busy2,
      input  rf_wr, rf_a3, rf_wd
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending multiply/divide write scoreboard: one busy bit per register.
// A set from issue takes precedence over a clear from writeback for the same register.
module rf_scoreboard #(
   parameter int unsigned AW = mcpu_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   output logic          iss_ready,
   input  logic          clr_valid,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] q_a1,
   input  logic [AW-1:0] q_a2,
   output logic          q_busy1,
   output logic          q_busy2
);
   import mcpu_pkg::*;

   localparam int unsigned NR = 1 << AW;

   logic [NR-1:0] busy;
   logic [NR-1:0] busy_nxt;
   logic          rd_zero;

   assign rd_zero   = (iss_rd == AW'(REG_ZERO));
   assign iss_ready = en && (rd_zero || !busy[iss_rd]);
   assign q_busy1   = busy[q_a1];
   assign q_busy2   = busy[q_a2];

   always_comb begin
      busy_nxt = busy;
      if (clr_valid)
         busy_nxt[clr_addr] = 1'b0;
      if (iss_valid && iss_ready && !rd_zero)
         busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else if (en)
         busy <= busy_nxt;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between pipeline writeback (port 0) and
// multiply/divide writeback (port 1) with round-robin arbitration and a registered write.
module rf_wb_arbiter #(
   parameter int unsigned AW = mcpu_pkg::AW,
   parameter int unsigned DW = mcpu_pkg::DW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   rf_wb_arbiter_if.slave bus
);
   import mcpu_pkg::*;

   port_e last;
   port_e last_nxt;
   logic  gnt0;
   logic  gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= PORT1;
      else
         last <= last_nxt;
   end

   // On a tie, the port that did not win the previous transfer is granted.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      last_nxt = last;
      if (en) begin
         if (bus.wb0_valid && (!bus.wb1_valid || last == PORT1))
            gnt0 = 1'b1;
         else if (bus.wb1_valid)
            gnt1 = 1'b1;
      end
      if (gnt0)
         last_nxt = PORT0;
      else if (gnt1)
         last_nxt = PORT1;
   end

   assign bus.wb0_ready = gnt0;
   assign bus.wb1_ready = gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rf_wr <= 1'b0;
         bus.rf_a3 <= '0;
         bus.rf_wd <= '0;
      end else if (!en) begin
         bus.rf_wr <= 1'b0;
      end else begin
         bus.rf_wr <= (gnt0 && bus.wb0_addr != AW'(REG_ZERO)) ||
                      (gnt1 && bus.wb1_addr != AW'(REG_ZERO));
         if (gnt0) begin
            bus.rf_a3 <= bus.wb0_addr;
            bus.rf_wd <= bus.wb0_data;
         end else if (gnt1) begin
            bus.rf_a3 <= bus.wb1_addr;
            bus.rf_wd <= bus.wb1_data;
         end
      end
   end

   rf_scoreboard #(
      .AW(AW)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .iss_ready (bus.iss_ready),
      .clr_valid (gnt1),
      .clr_addr  (bus.wb1_addr),
      .q_a1      (bus.q_a1),
      .q_a2      (bus.q_a2),
      .q_busy1   (bus.q_busy1),
      .q_busy2   (bus.q_busy2)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter: arbitration, scoreboard, register 0, enable and reset.
module tb_rf_wb_arbiter;

   logic clk;
   logic rst;
   logic en;
   int   checks;
   int   errors;

   rf_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

   rf_wb_arbiter #(
      .AW(5),
      .DW(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb0_valid = 1'b0; bus.wb0_addr = '0; bus.wb0_data = '0;
      bus.wb1_valid = 1'b0; bus.wb1_addr = '0; bus.wb1_data = '0;
      bus.iss_valid = 1'b0; bus.iss_rd   = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle();
      en = 1'b1; rst = 1'b1;
      bus.q_a1 = 5'd8; bus.q_a2 = 5'd9;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr got %0h exp 0", bus.rf_wr); end
      checks++; if (bus.rf_a3 !== 5'd0) begin errors++; $display("FAIL reset_rf_a3 got %0h exp 0", bus.rf_a3); end
      checks++; if (bus.rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd got %0h exp 0", bus.rf_wd); end
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL reset_q_busy1 got %0h exp 0", bus.q_busy1); end
      rst = 1'b0;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %0h exp 1", bus.iss_ready); end
      checks++; if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b0)
         begin errors++; $display("FAIL reset_idle_ready got %0h%0h exp 00", bus.wb0_ready, bus.wb1_ready); end
   endtask

   task automatic test_single_write();
      bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'h1234_5678;
      #1;
      checks++; if (bus.wb0_ready !== 1'b1) begin errors++; $display("FAIL single_wb0_ready got %0h exp 1", bus.wb0_ready); end
      checks++; if (bus.wb1_ready !== 1'b0) begin errors++; $display("FAIL single_wb1_ready got %0h exp 0", bus.wb1_ready); end
      tick();
      bus.wb0_valid = 1'b0;
      checks++; if (bus.rf_wr !== 1'b1) begin errors++; $display("FAIL single_rf_wr got %0h exp 1", bus.rf_wr); end
      checks++; if (bus.rf_a3 !== 5'd5) begin errors++; $display("FAIL single_rf_a3 got %0h exp 5", bus.rf_a3); end
      checks++; if (bus.rf_wd !== 32'h1234_5678) begin errors++; $display("FAIL single_rf_wd got %0h exp 12345678", bus.rf_wd); end
      tick();
      checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL single_rf_wr_drop got %0h exp 0", bus.rf_wr); end
   endtask

   task automatic test_round_robin();
      logic       exp0;
      logic [4:0] exp_a3;
      apply_reset();
      bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'hAAAA_0003;
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd4; bus.wb1_data = 32'hBBBB_0004;
      for (int i = 0; i < 4; i++) begin
         exp0   = (i % 2 == 0);
         exp_a3 = exp0 ? 5'd3 : 5'd4;
         #1;
         checks++; if (bus.wb0_ready !== exp0 || bus.wb1_ready !== !exp0)
            begin errors++; $display("FAIL rr_grant[%0d] got %0h%0h exp %0h%0h", i, bus.wb0_ready, bus.wb1_ready, exp0, !exp0); end
         tick();
         checks++; if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== exp_a3)
            begin errors++; $display("FAIL rr_rf_a3[%0d] got wr=%0h a3=%0d exp wr=1 a3=%0d", i, bus.rf_wr, bus.rf_a3, exp_a3); end
      end
      idle();
      tick();
   endtask

   task automatic test_scoreboard();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd8; bus.q_a1 = 5'd8; bus.q_a2 = 5'd8;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sb_first_issue got %0h exp 1", bus.iss_ready); end
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_pre_busy got %0h exp 0", bus.q_busy1); end
      tick();
      checks++; if (bus.q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy1_set got %0h exp 1", bus.q_busy1); end
      checks++; if (bus.q_busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy2_set got %0h exp 1", bus.q_busy2); end
      checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sb_second_issue got %0h exp 0", bus.iss_ready); end
      bus.iss_valid = 1'b0;
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd8; bus.wb1_data = 32'hCAFE_0008;
      #1;
      checks++; if (bus.wb1_ready !== 1'b1) begin errors++; $display("FAIL sb_wb1_ready got %0h exp 1", bus.wb1_ready); end
      checks++; if (bus.q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_before_clear got %0h exp 1", bus.q_busy1); end
      tick();
      bus.wb1_valid = 1'b0;
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared got %0h exp 0", bus.q_busy1); end
      checks++; if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== 5'd8 || bus.rf_wd !== 32'hCAFE_0008)
         begin errors++; $display("FAIL sb_wb1_write got wr=%0h a3=%0d wd=%0h exp wr=1 a3=8 wd=cafe0008", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd8;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sb_reissue got %0h exp 1", bus.iss_ready); end
      bus.iss_valid = 1'b0;
   endtask

   task automatic test_set_clear_same();
      bus.q_a1 = 5'd9; bus.q_a2 = 5'd11;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h0000_0099;
      #1;
      checks++; if (bus.iss_ready !== 1'b1 || bus.wb1_ready !== 1'b1)
         begin errors++; $display("FAIL setclr_ready got iss=%0h wb1=%0h exp 1 1", bus.iss_ready, bus.wb1_ready); end
      tick();
      bus.iss_valid = 1'b0;
      checks++; if (bus.q_busy1 !== 1'b1) begin errors++; $display("FAIL setclr_busy9 got %0h exp 1", bus.q_busy1); end
      checks++; if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== 5'd9 || bus.rf_wd !== 32'h0000_0099)
         begin errors++; $display("FAIL setclr_write got wr=%0h a3=%0d wd=%0h exp wr=1 a3=9 wd=99", bus.rf_wr, bus.rf_a3, bus.rf_wd); end
      bus.wb1_addr = 5'd11; bus.wb1_data = 32'h0000_0011;
      tick();
      bus.wb1_valid = 1'b0;
      checks++; if (bus.q_busy2 !== 1'b0 || bus.q_busy1 !== 1'b1)
         begin errors++; $display("FAIL nonbusy_wb1_busy got b11=%0h b9=%0h exp 0 1", bus.q_busy2, bus.q_busy1); end
      checks++; if (bus.rf_wr !== 1'b1 || bus.rf_a3 !== 5'd11)
         begin errors++; $display("FAIL nonbusy_wb1_write got wr=%0h a3=%0d exp wr=1 a3=11", bus.rf_wr, bus.rf_a3); end
   endtask

   task automatic test_reg_zero();
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd0; bus.wb1_data = 32'hFFFF_FFFF;
      #1;
      checks++; if (bus.wb1_ready !== 1'b1) begin errors++; $display("FAIL r0_wb1_ready got %0h exp 1", bus.wb1_ready); end
      tick();
      bus.wb1_valid = 1'b0;
      checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL r0_rf_wr got %0h exp 0", bus.rf_wr); end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.q_a1 = 5'd0;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL r0_iss_ready got %0h exp 1", bus.iss_ready); end
      tick();
      bus.iss_valid = 1'b0;
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL r0_q_busy got %0h exp 0", bus.q_busy1); end
   endtask

   task automatic test_enable();
      bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd6; bus.wb0_data = 32'h0000_0066;
      tick();
      en = 1'b0;
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd7; bus.wb1_data = 32'h0000_0077;
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd10; bus.q_a1 = 5'd10;
      #1;
      checks++; if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b0 || bus.iss_ready !== 1'b0)
         begin errors++; $display("FAIL en_readies got %0h%0h%0h exp 000", bus.wb0_ready, bus.wb1_ready, bus.iss_ready); end
      tick();
      checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL en_rf_wr got %0h exp 0", bus.rf_wr); end
      checks++; if (bus.rf_a3 !== 5'd6 || bus.rf_wd !== 32'h0000_0066)
         begin errors++; $display("FAIL en_hold got a3=%0d wd=%0h exp a3=6 wd=66", bus.rf_a3, bus.rf_wd); end
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL en_no_set got %0h exp 0", bus.q_busy1); end
      // Port 0 won last before en dropped, so the tie must now go to port 1.
      en = 1'b1;
      #1;
      checks++; if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b1)
         begin errors++; $display("FAIL en_last_hold got %0h%0h exp 01", bus.wb0_ready, bus.wb1_ready); end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd12; bus.q_a1 = 5'd12;
      tick();
      bus.iss_valid = 1'b0;
      bus.wb0_valid = 1'b1; bus.wb0_addr = 5'd13; bus.wb0_data = 32'h0000_0013;
      bus.wb1_valid = 1'b1; bus.wb1_addr = 5'd14; bus.wb1_data = 32'h0000_0014;
      tick();
      checks++; if (bus.rf_wr !== 1'b1 || bus.q_busy1 !== 1'b1)
         begin errors++; $display("FAIL mid_pre got wr=%0h busy=%0h exp 1 1", bus.rf_wr, bus.q_busy1); end
      rst = 1'b1;
      #1;
      checks++; if (bus.rf_wr !== 1'b0 || bus.rf_a3 !== 5'd0)
         begin errors++; $display("FAIL mid_rf_async got wr=%0h a3=%0d exp 0 0", bus.rf_wr, bus.rf_a3); end
      checks++; if (bus.q_busy1 !== 1'b0) begin errors++; $display("FAIL mid_busy_clear got %0h exp 0", bus.q_busy1); end
      rst = 1'b0;
      #1;
      checks++; if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0)
         begin errors++; $display("FAIL mid_first_tie got %0h%0h exp 10", bus.wb0_ready, bus.wb1_ready); end
      idle();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_scoreboard();
      test_set_clear_same();
      test_reg_zero();
      test_enable();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
